// File: rtl/spsram_pkg.sv
// spsram_pkg: shared state encoding, default widths and bank geometry helpers
package spsram_pkg;
  typedef enum logic {S_CLR = 1'b0, S_IDLE = 1'b1} state_t;
  localparam int BW_DATA_DEF = 32;
  localparam int BW_ADDR_DEF = 5;
  function automatic int nb_of(input int bw_bank);
    return 1 << bw_bank;
  endfunction
  function automatic int d_of(input int bw_addr, input int bw_bank);
    return 1 << (bw_addr - bw_bank);
  endfunction
endpackage

// File: rtl/spsram_be_bank.sv
// spsram_be_bank: single-port byte-enabled bank with registered read data
module spsram_be_bank #(
  parameter int BW_DATA = 32,
  parameter int BW_ROW  = 4
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [BW_DATA/8-1:0] be,
  input  logic [BW_ROW-1:0]    row,
  input  logic [BW_DATA-1:0]   wdata,
  output logic [BW_DATA-1:0]   rdata
);
  logic [BW_DATA-1:0] mem [2**BW_ROW];
  // byte-masked write, or capture of the addressed row on a read
  always_ff @(posedge clk) begin
    if (en & we)
      for (int k = 0; k < BW_DATA/8; k++)
        if (be[k]) mem[row][8*k +: 8] <= wdata[8*k +: 8];
    if (en & ~we) rdata <= mem[row];
  end
endmodule

// File: rtl/spsram_banked.sv
// spsram_banked: multi-bank byte-enabled SRAM with registered read and zero-fill sequencer
module spsram_banked
  import spsram_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int BW_ADDR = BW_ADDR_DEF,
  parameter int BW_BANK = 1,
  parameter int OUT_REG = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_cen,
  input  logic                 i_wen,
  input  logic                 i_oen,
  input  logic [BW_ADDR-1:0]   i_addr,
  input  logic [BW_DATA/8-1:0] i_be,
  input  logic [BW_DATA-1:0]   i_data,
  output logic                 o_ready,
  output logic                 o_rvalid,
  output logic [BW_DATA-1:0]   o_data,
  output logic                 o_busy_clr
);
  localparam int NB     = nb_of(BW_BANK);
  localparam int D      = d_of(BW_ADDR, BW_BANK);
  localparam int BW_ROW = BW_ADDR - BW_BANK;
  localparam int BW_SEL = BW_BANK > 0 ? BW_BANK : 1;
  state_t state, state_n;
  logic [BW_ROW-1:0] cnt, cnt_n, row;
  logic [BW_SEL-1:0] sel, sel1;
  logic [BW_DATA-1:0] rdata [NB];
  logic [BW_DATA-1:0] d1;
  logic clearing, acc, rd, v1, oen1;
  assign clearing   = state == S_CLR;
  assign o_ready    = state == S_IDLE;
  assign o_busy_clr = clearing;
  assign acc        = i_cen & o_ready;
  assign rd         = acc & ~i_wen;
  assign sel        = BW_SEL'(i_addr >> BW_ROW);
  assign row        = clearing ? cnt : i_addr[BW_ROW-1:0];
  // state and clear-row counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_CLR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // clear walks every row once; a clear request in idle restarts the walk at row 0
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    if (clearing) begin
      cnt_n   = cnt + 1'b1;
      state_n = cnt == BW_ROW'(D - 1) ? S_IDLE : S_CLR;
    end else if (i_clr) begin
      state_n = S_CLR;
    end
  end
  genvar b;
  generate
    for (b = 0; b < NB; b++) begin : g_bank
      spsram_be_bank #(.BW_DATA(BW_DATA), .BW_ROW(BW_ROW)) u_bank (
        .clk  (i_clk),
        .en   (clearing | (acc & sel == BW_SEL'(b))),
        .we   (clearing | i_wen),
        .be   (clearing ? '1 : i_be),
        .row  (row),
        .wdata(clearing ? '0 : i_data),
        .rdata(rdata[b])
      );
    end
  endgenerate
  // read-valid, bank select and output enable travel with the bank's read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1   <= 1'b0;
      sel1 <= '0;
      oen1 <= 1'b0;
    end else begin
      v1 <= rd;
      if (rd) begin
        sel1 <= sel;
        oen1 <= i_oen;
      end
    end
  end
  assign d1 = v1 & oen1 ? rdata[sel1] : '0;
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic v2;
      logic [BW_DATA-1:0] d2;
      // optional output stage adds one cycle of read latency
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          d2 <= d1;
        end
      end
      assign o_rvalid = v2;
      assign o_data   = d2;
    end else begin : g_comb
      assign o_rvalid = v1;
      assign o_data   = d1;
    end
  endgenerate
endmodule

// File: doc/spsram_banked.md
# spsram_banked

Parametrised multi-bank single-port SRAM and the successor of the two-bank 32x32 SRAM wrapper. It splits a flat address space across 2^BW_BANK banks selected by the address MSBs. It adds:
- byte-write enables
- a registered read path with an explicit read-valid, plus an optional output pipeline register
- a hardware clear sequencer that zero-fills every bank after reset or on request

It sits between a simple master (CPU/testbench port) and on-chip storage wherever a zero-initialised scratch memory is needed.

## Interface
- BW_DATA, 32, data width; multiple of 8
- BW_ADDR, 5, total word-address width
- BW_BANK, 1, log2 of bank count; 0 <= BW_BANK < BW_ADDR
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_clr  in  1  request zero-fill of all banks; sampled in S_IDLE only
- i_cen  in  1  request strobe; accepted only when o_ready=1
- i_wen  in  1  1=write, 0=read
- i_oen  in  1  read output enable, sampled with the read request
- i_addr  in  BW_ADDR  word address; [BW_ADDR-1 -: BW_BANK] selects the bank, low bits select the row
- i_be  in  BW_DATA/8  byte write enables
- i_data  in  BW_DATA  write data
- o_ready  out  1  1 in S_IDLE, 0 while clearing
- o_rvalid  out  1  read data valid, one-cycle pulse per accepted read
- o_data  out  BW_DATA  read data; 0 whenever o_rvalid=0
- o_busy_clr  out  1  1 in S_CLR

## Operation
- Bank geometry:
  - banks NB = 2^BW_BANK
  - rows per bank D = 2^(BW_ADDR-BW_BANK)
  - row address = i_addr[BW_ADDR-BW_BANK-1:0]
- FSM states: S_CLR, S_IDLE.
  - Reset enters S_CLR with the row counter at 0.
  - S_CLR: every cycle, write 0 to row counter in all banks in parallel, with all bytes enabled; then increment the counter.
  - On the cycle the counter = D-1, write that row, then go to S_IDLE.
  - S_IDLE with i_clr=1 and no accepted request in the same cycle: go to S_CLR with the counter at 0.
  - If i_clr and i_cen are both 1 in S_IDLE, the request is accepted and the clear starts the next cycle.
- Accept condition: i_cen & o_ready. Requests with o_ready=0 are dropped silently: no write, no o_rvalid.
- Write: only the selected bank is enabled. Byte k updates iff i_be[k]; other bytes keep their old value. i_be=0 performs no write. No o_rvalid.
- Read: only the selected bank is enabled.
  - The bank registers its row data at the edge. Bank select and i_oen are registered alongside the data.
  - The output mux picks the registered bank.
  - If the sampled i_oen=0, o_rvalid still pulses and o_data=0.
- Write then read of the same address on consecutive cycles returns the new data; no bypass is needed because the port is single.
- Reads in flight when a clear starts still complete with the pre-clear data.
- Reset mid-operation: pipeline valids clear asynchronously, and in-flight reads are lost. The FSM returns to S_CLR and memory is re-zeroed.

## Timing
- Reset values:
  - o_ready=0, o_rvalid=0, o_data=0, o_busy_clr=1
  - state S_CLR, counter 0, pipeline select/oen registers 0
- Clear duration: D cycles after reset release. o_ready rises on the edge ending the last clear write. With the defaults (D=16), o_ready=1 from cycle 16 after reset release.
- Read latency, OUT_REG=0: request accepted at edge N gives o_rvalid=1 and data during the cycle after edge N.
- Read latency, OUT_REG=1: the same request gives valid data one edge later.
- Fully pipelined throughput: one read or one write per cycle. Back-to-back reads to different banks produce consecutive o_rvalid pulses in issue order.
- o_ready is a registered function of state only and never depends combinationally on i_cen.

## Structure
- Shared package spsram_pkg holds:
  - state encoding constants S_CLR=1'b0, S_IDLE=1'b1
  - default BW_DATA/BW_ADDR values
  - the localparam formulas for NB and D
- One sub-module, spsram_be_bank: single-port, byte-enabled, registered-read bank with parameters BW_DATA and BW_ROW. It is instantiated NB times in a generate loop.
- The top holds the FSM, row counter, bank decode, select/oen pipeline, output mux and optional output register.

## Test plan
- Reset release with defaults: o_ready=0 for exactly 16 cycles, then 1. Reading addresses 0..31 returns 0x00000000 for all.
- Write 0xDEADBEEF to addr 3 and 0x12345678 to addr 19, then read both: returns the respective values. This checks that bank 0 and bank 1 are distinct rows.
- Write 0xFFFFFFFF to addr 7, then write 0x000000AB with i_be=4'b0001: a read returns 0xFFFFFFAB. A write with i_be=0 leaves it unchanged.
- Back-to-back reads of addr 3, 19 and 3, with i_oen=1, 0, 1: o_rvalid is high for 3 consecutive cycles with data 0xDEADBEEF, 0x0, 0xDEADBEEF. Repeat with OUT_REG=1 to check the +1 latency shift.
- Assert i_clr in S_IDLE with a read issued the cycle before: the read returns old data, o_ready is low for 16 cycles, an i_cen during the clear is dropped, and all addresses read 0 afterwards.
- Assert i_rst for 1 cycle mid-burst of reads: o_rvalid drops immediately, the 16-cycle clear restarts, and previously written data reads back as 0.
